calculate_seq: RTL

Multi-cycle successor to the single-cycle calculator core, parametrised in operand width. Performs signed + − × ÷ % on two operands from the keypad front end. Multiply, divide and modulo use an iterative shift unit instead of combinational operators. Produces a display-range-checked result, or the error code, for segment_driver, framed by a start/busy/done handshake.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 68 ++++++
 rtl/calculate_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared operator codes, display limits, error glyph and FSM encoding for the
// sequential calculator.
package calc_pkg;

    localparam logic [2:0] OP_PLUS     = 3'd1;
    localparam logic [2:0] OP_MINUS    = 3'd2;
    localparam logic [2:0] OP_MULTIPLE = 3'd3;
    localparam logic [2:0] OP_DIVIDE   = 3'd4;
    localparam logic [2:0] OP_MODULO   = 3'd5;

    localparam int          MAX_POS  = 999999;
    localparam int          MIN_NEG  = -99999;
    localparam logic [31:0] ERR_CODE = 32'h00EE_0000;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix,
        StDone
    } state_t;

    function automatic logic op_valid(input logic [2:0] op);
        return (op >= OP_PLUS) && (op <= OP_MODULO);
    endfunction

    function automatic logic op_divlike(input logic [2:0] op);
        return (op == OP_DIVIDE) || (op == OP_MODULO);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// WIDTH-step unsigned shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator: high half is partial product / remainder.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_mode_div,
    input  logic [WIDTH-1:0]   i_mag_a,
    input  logic [WIDTH-1:0]   i_mag_b,
    output logic               o_last,
    output logic [2*WIDTH-1:0] o_product,
    output logic [WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]   o_remainder
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_div;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_acc_next;

    always_comb begin
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_b};
        if (r_div) begin
            // Remainder stays below the divisor, so a successful trial fits in WIDTH bits.
            if (w_diff[WIDTH+1]) begin
                w_acc_next = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end else begin
                w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, i_mag_a};
            r_b   <= i_mag_b;
            r_div <= i_mode_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last      = (r_cnt == CW'(WIDTH - 1));
    assign o_product   = r_acc;
    assign o_quotient  = r_acc[WIDTH-1:0];
    assign o_remainder = r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/calculate_seq.sv
// Multi-cycle signed calculator: FSM, sign handling and display range check
// around the iterative multiply/divide unit.
module calculate_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    sw_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] operand1,
    input  logic signed [WIDTH-1:0] operand2,
    input  logic [2:0]              operator,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] ans,
    output logic                    err
);
    // Wide enough to hold any full-precision result with its sign.
    localparam int unsigned RW = 2 * WIDTH + 2;
    localparam logic signed [RW-1:0] ResMax = RW'(MAX_POS);
    localparam logic signed [RW-1:0] ResMin = RW'(MIN_NEG);

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_op1;
    logic signed [WIDTH-1:0] r_op2;
    logic [2:0]              r_opcode;

    logic                    w_load;
    logic                    w_step;
    logic                    w_last;
    logic [WIDTH-1:0]        w_mag1;
    logic [WIDTH-1:0]        w_mag2;
    logic [2*WIDTH-1:0]      w_prod;
    logic [WIDTH-1:0]        w_quot;
    logic [WIDTH-1:0]        w_rem;
    logic signed [RW-1:0]    w_ext1;
    logic signed [RW-1:0]    w_ext2;
    logic signed [RW-1:0]    w_result;
    logic                    w_div0;
    logic                    w_err;
    logic                    w_iter_op;

    assign w_mag1    = operand1[WIDTH-1] ? ('0 - operand1) : operand1;
    assign w_mag2    = operand2[WIDTH-1] ? ('0 - operand2) : operand2;
    assign w_load    = (r_state == StIdle) && start;
    assign w_step    = (r_state == StIter);
    assign w_iter_op = (operator == OP_MULTIPLE) || (op_divlike(operator) && (operand2 != '0));

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .i_clk       (sw_clk),
        .i_rst_n     (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_mode_div  (op_divlike(operator)),
        .i_mag_a     (w_mag1),
        .i_mag_b     (w_mag2),
        .o_last      (w_last),
        .o_product   (w_prod),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    assign w_ext1 = {{(RW-WIDTH){r_op1[WIDTH-1]}}, r_op1};
    assign w_ext2 = {{(RW-WIDTH){r_op2[WIDTH-1]}}, r_op2};
    assign w_div0 = op_divlike(r_opcode) && (r_op2 == '0);

    always_comb begin
        w_result = '0;
        case (r_opcode)
            OP_PLUS:     w_result = w_ext1 + w_ext2;
            OP_MINUS:    w_result = w_ext1 - w_ext2;
            OP_MULTIPLE: w_result = (r_op1[WIDTH-1] ^ r_op2[WIDTH-1])
                                    ? ('0 - {2'b00, w_prod}) : {2'b00, w_prod};
            OP_DIVIDE:   w_result = (r_op1[WIDTH-1] ^ r_op2[WIDTH-1])
                                    ? ('0 - {{(RW-WIDTH){1'b0}}, w_quot})
                                    : {{(RW-WIDTH){1'b0}}, w_quot};
            OP_MODULO:   w_result = r_op1[WIDTH-1]
                                    ? ('0 - {{(RW-WIDTH){1'b0}}, w_rem})
                                    : {{(RW-WIDTH){1'b0}}, w_rem};
            default:     w_result = '0;
        endcase
        w_err = !op_valid(r_opcode) || w_div0 || (w_result > ResMax) || (w_result < ResMin);
    end

    always_ff @(posedge sw_clk) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_op1    <= '0;
            r_op2    <= '0;
            r_opcode <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ans      <= '0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_op1    <= operand1;
                        r_op2    <= operand2;
                        r_opcode <= operator;
                        busy     <= 1'b1;
                        r_state  <= w_iter_op ? StIter : StFix;
                    end
                end
                StIter: begin
                    if (w_last) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    ans     <= w_err ? WIDTH'(ERR_CODE) : w_result[WIDTH-1:0];
                    err     <= w_err;
                    busy    <= 1'b0;
                    r_state <= StDone;
                end
                StDone: begin
                    done    <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
